// File: rtl/audio_upsampler.sv
// Sample-rate upsampler: 2-entry input FIFO feeding a per-segment linear ramp (or zero-order hold).
// Define UPSAMPLER_LINEAR_EN for linear interpolation; the default build holds each sample for a segment.
module audio_upsampler #(
  parameter int PERIOD_LOG2 = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic signed [15:0] current_sample,
  output logic               sample_req,
  output logic        [7:0]  underrun_count
);

  localparam int ACC_W = 16 + PERIOD_LOG2;
  localparam logic [PERIOD_LOG2-1:0] PHASE_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

  logic        [1:0]             count;
  logic signed [15:0]            fifo_mem [2];
  logic        [PERIOD_LOG2-1:0] phase;
  logic signed [15:0]            s1;
  logic signed [ACC_W-1:0]       acc;
  state_t                        state;
  logic                          boundary;
  logic                          push;
  logic                          pop;

`ifdef UPSAMPLER_LINEAR_EN
  logic signed [15:0] s0;
  logic signed [16:0] delta;

  // delta is derived from the registered endpoints, so it is valid on the first edge after a boundary
  assign delta = {s1[15], s1} - {s0[15], s0};

  function automatic logic signed [ACC_W-1:0] sext_delta(input logic signed [16:0] d);
    return {{(ACC_W-17){d[16]}}, d};
  endfunction
`endif

  function automatic logic signed [ACC_W-1:0] scale_up(input logic signed [15:0] s);
    return {s, {PERIOD_LOG2{1'b0}}};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign boundary       = (phase == PHASE_MAX);
  assign sample_ready   = (count < 2'd2);
  assign push           = sample_valid && sample_ready;
  assign pop            = boundary && (count != 2'd0);
  assign current_sample = acc[ACC_W-1:PERIOD_LOG2];

  // FIFO storage: data only, occupancy lives in count
  always_ff @(posedge clk) begin
    if (pop) begin
      fifo_mem[0] <= push ? sample_in : fifo_mem[1];
    end else if (push) begin
      fifo_mem[count[0]] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= 2'd0;
      phase          <= '0;
      s1             <= '0;
      acc            <= '0;
      state          <= IDLE;
      sample_req     <= 1'b0;
      underrun_count <= 8'd0;
`ifdef UPSAMPLER_LINEAR_EN
      s0             <= '0;
`endif
    end else begin
      phase      <= phase + 1'b1;
      sample_req <= boundary;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // segment boundary: reload the accumulator and fetch the next endpoint
      if (boundary) begin
`ifdef UPSAMPLER_LINEAR_EN
        s0  <= s1;
        acc <= scale_up(s1);
`else
        acc <= scale_up(pop ? fifo_mem[0] : s1);
`endif
        if (pop) begin
          s1    <= fifo_mem[0];
          state <= RUN;
        end else if (state != IDLE) begin
          state          <= STARVE;
          underrun_count <= sat_inc(underrun_count);
        end
      end
`ifdef UPSAMPLER_LINEAR_EN
      else begin
        acc <= acc + sext_delta(delta);
      end
`endif
    end
  end

endmodule

// File: doc/audio_upsampler.md
AUDIO_UPSAMPLER -- requirements
Module: audio_upsampler

Interface
REQ-001 SHALL have parameter PERIOD_LOG2, default 11, meaning output segment length of 2^PERIOD_LOG2 clocks (11 gives 48.83 kHz at 100 MHz); legal range 4..16.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sample_in  input  16  signed two's-complement audio sample.
REQ-005 SHALL have port sample_valid  input  1  sample_in is offered this cycle.
REQ-006 SHALL have port sample_ready  output  1  a sample is accepted when valid and ready are both 1 at a rising edge.
REQ-007 SHALL have port current_sample  output  16  signed interpolated sample, fed to the delta-sigma DAC input.
REQ-008 SHALL have port sample_req  output  1  one-cycle pulse per segment boundary, for upstream pacing.
REQ-009 SHALL have port underrun_count  output  8  saturating count of starved segments.

Function
REQ-010 SHALL hold a 2-entry FIFO of accepted samples; sample_ready = (count < 2), combinational from the registered count.
REQ-011 SHALL run a free-running phase counter of PERIOD_LOG2 bits; a boundary edge is any edge at which phase == 2^PERIOD_LOG2-1, after which phase wraps to 0.
REQ-012 SHALL keep registers s0 (segment start), s1 (segment end), 17-bit signed delta = s1-s0, and accumulator acc of 16+PERIOD_LOG2 bits; current_sample = acc[PERIOD_LOG2+15:PERIOD_LOG2] (arithmetic floor).
REQ-013 SHALL on each non-boundary edge do acc <= acc + sign-extended delta.
REQ-014 SHALL on each boundary edge do s0 <= s1, acc <= s1<<PERIOD_LOG2; then s1 <= popped FIFO head if the FIFO is non-empty, else s1 <= old s1 (delta 0).
REQ-015 SHALL implement FSM IDLE/RUN/STARVE: IDLE -> RUN at a boundary with FIFO non-empty; RUN -> STARVE at a boundary with FIFO empty; STARVE -> RUN at a boundary with FIFO non-empty; IDLE stays IDLE and outputs 0.
REQ-016 SHALL increment underrun_count on every boundary that enters or remains in STARVE, saturating at 255; IDLE never counts.
REQ-017 SHALL, on a push and pop at the same edge, pop the old head, append the new sample, and leave count unchanged; with count 2, no push can occur (ready 0).
REQ-018 SHALL assert sample_req for exactly the one cycle following each boundary edge.
REQ-019 SHALL give a pushed sample a latency to current_sample equal to the FIFO entries ahead of it plus the wait to the next boundary; the value is reached exactly 2^PERIOD_LOG2 clocks after its pop.

Reset
REQ-020 SHALL, while rst_n=0, force: FIFO empty, phase=0, s0=s1=acc=delta=0, FSM=IDLE, current_sample=0, sample_ready=1, sample_req=0, underrun_count=0.
REQ-021 SHALL discard the FIFO contents and any ramp in progress on reset mid-segment; the first boundary after release is 2^PERIOD_LOG2 edges later.

Configuration
REQ-022 SHALL, with macro UPSAMPLER_LINEAR_EN defined, interpolate linearly per REQ-013/014.
REQ-023 SHALL, without UPSAMPLER_LINEAR_EN, treat delta as constant 0 and load acc <= popped sample<<PERIOD_LOG2 at the boundary (zero-order hold): output steps to each new sample at the boundary; FIFO, FSM, sample_req and underrun_count are unchanged.

Verification (PERIOD_LOG2=4, linear unless noted)
REQ-024 SHALL check reset: drop rst_n mid-ramp -> current_sample=0, sample_ready=1, underrun_count=0 immediately and asynchronously.
REQ-025 SHALL check the ramp: push 0x0100 in IDLE -> after the first boundary, outputs 0x0000,0x0010,...,0x00F0 on successive clocks, then 0x0100 after the next boundary.
REQ-026 SHALL check the extreme negative step: s0=0x7FFF, s1=0x8000 -> output 0x6FFF one clock after the boundary and 0x8000 after 16 clocks, with no wrap.
REQ-027 SHALL check starvation: no further push after 0x0100 -> holds 0x0100, underrun_count=1, then 2; push 0x0200 -> ramps 0x0100->0x0200 over 16 clocks and count stays 2.
REQ-028 SHALL check backpressure: 3 back-to-back valid pushes in IDLE -> third held off with sample_ready=0 until the boundary pop, then accepted.
REQ-029 SHALL check hold mode: UPSAMPLER_LINEAR_EN undefined, push 0x0100 then 0x0200 -> output steps 0 -> 0x0100 -> 0x0200 exactly at boundaries.
